// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier job queue.
package mult_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitHi,
        StWaitLo,
        StHold
    } mult_state_e;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO with wrap-around pointers one bit wider than the index.
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2 * OP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    // A push while full is dropped so stored entries are untouched.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mult_job_queue.sv
// Queues operand pairs and sequences them through an external multiplier.
// Optional completed-job counter enabled by defining MULT_JOB_CNT_EN.
module mult_job_queue
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_busy,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product
`ifdef MULT_JOB_CNT_EN
    ,
    output logic [15:0]       job_cnt
`endif
);

    mult_state_e         state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                valid_q, valid_d;
    logic                pop, full, empty;
    logic [2*OP_W-1:0]   head;

    mult_op_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OP_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   ({in_a, in_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // in_ready depends only on registered occupancy, never on this cycle's pop.
    assign in_ready    = !full;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign out_valid   = valid_q;
    assign out_product = prod_q;

    // Next-state and datapath control for the job sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        valid_d   = valid_q;
        pop       = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    a_d     = head[2*OP_W-1:OP_W];
                    b_d     = head[OP_W-1:0];
                    state_d = StStart;
                end
            end
            StStart: begin
                mul_start = 1'b1;
                state_d   = StWaitHi;
            end
            StWaitHi: begin
                if (mul_busy) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!mul_busy) begin
                    prod_d  = mul_product;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

`ifdef MULT_JOB_CNT_EN
    logic [15:0] job_cnt_q;
    logic        job_done;

    assign job_done = (state_q == StHold) && out_ready;
    assign job_cnt  = job_cnt_q;

    // Completed-job counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            job_cnt_q <= '0;
        end else if (job_done) begin
            job_cnt_q <= job_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_job_queue.sv
// Directed self-checking bench for mult_job_queue with a behavioural multiplier.
module tb_mult_job_queue;
    import mult_pkg::*;

    localparam int unsigned BUSY_LEN = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_a = '0;
    logic [OP_W-1:0]   in_b = '0;
    logic              mul_start;
    logic [OP_W-1:0]   mul_a, mul_b;
    logic              mul_busy;
    logic [PROD_W-1:0] mul_product;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PROD_W-1:0] out_product;
`ifdef MULT_JOB_CNT_EN
    logic [15:0]       job_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mult_job_queue #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
`ifdef MULT_JOB_CNT_EN
        ,
        .job_cnt     (job_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier: busy for BUSY_LEN cycles after a start, product ready when busy drops.
    int unsigned       busy_cnt;
    logic [PROD_W-1:0] mprod_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt <= 0;
            mprod_q  <= '0;
        end else if (mul_start) begin
            busy_cnt <= BUSY_LEN;
            mprod_q  <= {32'b0, mul_a} * {32'b0, mul_b};
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mul_busy    = (busy_cnt != 0);
    assign mul_product = mprod_q;

    int starts;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starts <= 0;
        else if (mul_start) starts <= starts + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [31:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; returns edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got %b want 0", mul_start); end
        checks++; if (mul_a !== 32'd0) begin errors++; $display("FAIL rst_mul_a got %h want 0", mul_a); end
        checks++; if (mul_b !== 32'd0) begin errors++; $display("FAIL rst_mul_b got %h want 0", mul_b); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_product !== 64'd0) begin errors++; $display("FAIL rst_out_product got %h want 0", out_product); end
`ifdef MULT_JOB_CNT_EN
        checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL rst_job_cnt got %h want 0", job_cnt); end
`endif
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        int s0;
        out_ready = 1'b1;
        s0 = starts;
        do_push(32'd3, 32'd5);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || out_product !== 64'd15) begin
            errors++; $display("FAIL single_product got v=%b %0d want v=1 15", out_valid, out_product); end
        checks++; if (n != 3 + BUSY_LEN) begin
            errors++; $display("FAIL single_latency got %0d want %0d", n, 3 + BUSY_LEN); end
        tick();
        repeat (10) tick();
        checks++; if (starts - s0 != 1) begin
            errors++; $display("FAIL single_starts got %0d want 1", starts - s0); end
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle_valid got %b want 0", out_valid); end
`ifdef MULT_JOB_CNT_EN
        checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL single_job_cnt got %0d want 1", job_cnt); end
`endif
    endtask

    task automatic test_extremes();
        int n;
        out_ready = 1'b1;
        do_push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || out_product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL ext_max got v=%b %h want v=1 fffffffe00000001", out_valid, out_product); end
        tick();
        do_push(32'h0, 32'h1234_5678);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || out_product !== 64'd0) begin
            errors++; $display("FAIL ext_zero got v=%b %h want v=1 0", out_valid, out_product); end
        tick();
    endtask

    task automatic test_back_pressure();
        int n;
        int s0;
        out_ready = 1'b0;
        do_push(32'd6, 32'd7);
        do_push(32'd10, 32'd20);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || out_product !== 64'd42) begin
            errors++; $display("FAIL bp_first got v=%b %0d want v=1 42", out_valid, out_product); end
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_product !== 64'd42) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b %0d want v=1 42", i, out_valid, out_product); end
        end
        checks++; if (starts != s0) begin
            errors++; $display("FAIL bp_no_start got %0d starts want 0", starts - s0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (mul_start !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle got start=%b v=%b want 0 0", mul_start, out_valid); end
        tick();
        checks++; if (mul_start !== 1'b1) begin
            errors++; $display("FAIL bp_next_start got %b want 1", mul_start); end
        out_ready = 1'b1;
        wait_valid(n);
        checks++; if (out_valid !== 1'b1 || out_product !== 64'd200) begin
            errors++; $display("FAIL bp_second got v=%b %0d want v=1 200", out_valid, out_product); end
        tick();
    endtask

    task automatic test_fill();
        int n;
        int acc;
        logic [63:0] exp [4];
        exp[0] = 64'd2; exp[1] = 64'd12; exp[2] = 64'd30; exp[3] = 64'd56;
        out_ready = 1'b0;
        do_push(32'd7, 32'd7);
        wait_valid(n);
        // Sequencer now parked in HOLD, so the FIFO alone absorbs the burst.
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_a = 32'(2 * k + 1);
            in_b = 32'(2 * k + 2);
            if (in_ready === 1'b1) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL fill_accepted got %0d want 4", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_product !== 64'd49) begin
            errors++; $display("FAIL fill_head got v=%b %0d want v=1 49", out_valid, out_product); end
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            checks++; if (out_valid !== 1'b1 || out_product !== exp[k]) begin
                errors++; $display("FAIL fill_order_%0d got v=%b %0d want v=1 %0d", k, out_valid, out_product, exp[k]); end
            tick();
        end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid === 1'b1) n++;
            tick();
        end
        checks++; if (n != 0) begin errors++; $display("FAIL fill_extra got %0d valid cycles want 0", n); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_drained got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        do_push(32'd2, 32'd3);
        do_push(32'd4, 32'd5);
        do_push(32'd6, 32'd7);
        n = 0;
        while (mul_busy !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_seen got %b want 1", mul_busy); end
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL mid_mul_start got %b want 0", mul_start); end
        checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
            errors++; $display("FAIL mid_operands got %h %h want 0 0", mul_a, mul_b); end
        checks++; if (out_valid !== 1'b0 || out_product !== 64'd0) begin
            errors++; $display("FAIL mid_out got v=%b %h want 0 0", out_valid, out_product); end
`ifdef MULT_JOB_CNT_EN
        checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL mid_job_cnt got %0d want 0", job_cnt); end
`endif
        tick();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid === 1'b1 || mul_start === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles want 0", n); end
    endtask

`ifdef MULT_JOB_CNT_EN
    task automatic test_wrap();
        int n;
        dut.job_cnt_q = 16'hFFFF;
        out_ready = 1'b1;
        do_push(32'd1, 32'd1);
        wait_valid(n);
        tick();
        checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL wrap_job_cnt got %h want 0", job_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_pressure();
        test_fill();
        test_reset_mid();
`ifdef MULT_JOB_CNT_EN
        test_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
